// File: rtl/gpio_input_conditioner.sv
// Board KEY/SW conditioner: 2-FF sync, tick-based debounce, polarity fix, rise/fall/change pulses; no backpressure.
// Pin-to-clean_out latency (STABLE_TICKS-1)*TICK_CYCLES+3 .. STABLE_TICKS*TICK_CYCLES+3; sticky edge_latch with GPIO_COND_LATCH_EN.
`timescale 1ns/1ps
module gpio_input_conditioner #(
   parameter int             W            = 22,
   parameter logic [W-1:0]   INV_MASK     = 22'h00000F,
   parameter int             TICK_CYCLES  = 50000,
   parameter int             STABLE_TICKS = 10
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] raw_in,
   output logic [W-1:0] clean_out,
   output logic [W-1:0] rise_pulse,
   output logic [W-1:0] fall_pulse,
   output logic         any_change,
   input  logic [W-1:0] latch_clr,
   output logic [W-1:0] edge_latch
);

   localparam int PW = $clog2(TICK_CYCLES + 1);
   localparam int CW = $clog2(STABLE_TICKS + 1);

   logic [PW-1:0]         presc;
   logic                  tick;
   logic [W-1:0]          s1, s2;
   logic [W-1:0]          state, state_nxt;
   logic [W-1:0][CW-1:0]  cnt, cnt_nxt;
   logic [W-1:0]          clean_nxt, rise_nxt, fall_nxt;

   assign tick = (presc == PW'(TICK_CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // Any cycle where the synced pin agrees with the accepted level restarts the count,
   // so a glitch shorter than a tick period can never be accepted.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      for (int i = 0; i < W; i++) begin
         if (s2[i] == state[i]) begin
            cnt_nxt[i] = '0;
         end else if (tick) begin
            if (cnt[i] == CW'(STABLE_TICKS - 1)) begin
               state_nxt[i] = s2[i];
               cnt_nxt[i]   = '0;
            end else begin
               cnt_nxt[i] = cnt[i] + CW'(1);
            end
         end
      end
   end

   assign clean_nxt = state_nxt ^ INV_MASK;
   assign rise_nxt  = clean_nxt & ~clean_out;
   assign fall_nxt  = ~clean_nxt & clean_out;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1         <= INV_MASK;
         s2         <= INV_MASK;
         state      <= INV_MASK;
         cnt        <= '0;
         clean_out  <= '0;
         rise_pulse <= '0;
         fall_pulse <= '0;
         any_change <= 1'b0;
      end else begin
         s1         <= raw_in;
         s2         <= s1;
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         clean_out  <= clean_nxt;
         rise_pulse <= rise_nxt;
         fall_pulse <= fall_nxt;
         any_change <= |(rise_nxt | fall_nxt);
      end
   end

`ifdef GPIO_COND_LATCH_EN
   // A pulse in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edge_latch <= '0;
      end else begin
         edge_latch <= (edge_latch & ~latch_clr) | rise_pulse | fall_pulse;
      end
   end
`else
   logic unused_latch_clr;
   assign unused_latch_clr = ^latch_clr;
   assign edge_latch       = '0;
`endif

endmodule
